// File: rtl/fifo_rd_arbiter.sv
// Read-side controller for the async FIFO: round-robin read-port arbitration,
// read pointer ownership (binary + Gray), registered empty flag and occupancy.
module fifo_rd_arbiter #(
    parameter int ADDR_WIDTH = 3,
    parameter int NREQ       = 4,
    parameter int IDW        = 2
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic [ADDR_WIDTH:0]   rq2_wptr,
    input  logic [NREQ-1:0]       req,
    output logic [NREQ-1:0]       gnt,
    output logic                  rinc,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic                  rempty,
    output logic                  rd_valid,
    output logic [IDW-1:0]        rd_id,
    output logic [ADDR_WIDTH:0]   rd_level
);

    logic [ADDR_WIDTH:0] r_rbin;
    logic [ADDR_WIDTH:0] r_rptr;
    logic                r_rempty;
    logic                r_rd_valid;
    logic [IDW-1:0]      r_rd_id;
    logic [ADDR_WIDTH:0] r_rd_level;
    logic [IDW-1:0]      r_pri;

    logic [NREQ-1:0]     w_gnt;
    logic [IDW-1:0]      w_gnt_idx;
    logic                w_found;
    logic                w_rinc;
    logic [IDW-1:0]      w_pri_next;
    logic [ADDR_WIDTH:0] w_rbin_next;
    logic [ADDR_WIDTH:0] w_rgray_next;
    logic [ADDR_WIDTH:0] w_wbin;

    // Rotating search starting at r_pri; first requester found wins.
    always_comb begin
        int v_idx;
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_found   = 1'b0;
        v_idx     = 0;
        if (!rrst && !r_rempty) begin
            for (int k = 0; k < NREQ; k++) begin
                v_idx = int'(r_pri) + k;
                if (v_idx >= NREQ) begin
                    v_idx = v_idx - NREQ;
                end
                if (!w_found && req[v_idx]) begin
                    w_found       = 1'b1;
                    w_gnt[v_idx]  = 1'b1;
                    w_gnt_idx     = IDW'(v_idx);
                end
            end
        end
    end

    assign w_rinc       = w_found;
    assign w_pri_next   = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign w_rbin_next  = r_rbin + (ADDR_WIDTH + 1)'(w_rinc);
    assign w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;

    always_comb begin
        w_wbin             = '0;
        w_wbin[ADDR_WIDTH] = rq2_wptr[ADDR_WIDTH];
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
            w_wbin[i] = w_wbin[i+1] ^ rq2_wptr[i];
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_rbin     <= '0;
            r_rptr     <= '0;
            r_rempty   <= 1'b1;
            r_rd_valid <= 1'b0;
            r_rd_id    <= '0;
            r_rd_level <= '0;
            r_pri      <= '0;
        end else begin
            r_rbin     <= w_rbin_next;
            r_rptr     <= w_rgray_next;
            // Comparing against the post-read pointer keeps rempty low when
            // the last entry is read while new data has already arrived.
            r_rempty   <= (w_rgray_next == rq2_wptr);
            r_rd_valid <= w_rinc;
            r_rd_level <= w_wbin - w_rbin_next;
            if (w_rinc) begin
                r_rd_id <= w_gnt_idx;
                r_pri   <= w_pri_next;
            end
        end
    end

    assign gnt      = w_gnt;
    assign rinc     = w_rinc;
    assign raddr    = r_rbin[ADDR_WIDTH-1:0];
    assign rptr     = r_rptr;
    assign rempty   = r_rempty;
    assign rd_valid = r_rd_valid;
    assign rd_id    = r_rd_id;
    assign rd_level = r_rd_level;

endmodule
